// File: rtl/hamming_pkg.sv
// Shared Hamming(12,8) definitions for the FSK transmit encoder and the receive-side decoder.
// Codeword index i carries Hamming position i+1; parity sits on the power-of-two positions.
package hamming_pkg;

   localparam int CODE_W = 12;
   localparam int DATA_W = 8;

   localparam int P1_IDX = 0;
   localparam int P2_IDX = 1;
   localparam int P4_IDX = 3;
   localparam int P8_IDX = 7;

   // Data bits covered by each parity bit (bit n of a mask selects d<n>).
   localparam logic [DATA_W-1:0] P1_MASK = 8'b0101_1011;
   localparam logic [DATA_W-1:0] P2_MASK = 8'b0110_1101;
   localparam logic [DATA_W-1:0] P4_MASK = 8'b1000_1110;
   localparam logic [DATA_W-1:0] P8_MASK = 8'b1111_0000;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

   // Codeword index that carries data bit d<i>.
   function automatic int data_idx(input int i);
      int idx;
      case (i)
         0:       idx = 2;
         1:       idx = 4;
         2:       idx = 5;
         3:       idx = 6;
         4:       idx = 8;
         5:       idx = 9;
         6:       idx = 10;
         7:       idx = 11;
         default: idx = 2;
      endcase
      return idx;
   endfunction

   function automatic logic parity8(input logic [DATA_W-1:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/hamming_encode_12_8.sv
// Purely combinational Hamming(12,8) encoder; also reused by the decoder's test bench.
module hamming_encode_12_8
   import hamming_pkg::*;
(
   input  logic [DATA_W-1:0] data_i,
   output logic [CODE_W-1:0] code_o
);

   // Scatter data bits into their codeword slots, then fill in the parity slots.
   always_comb begin
      code_o = {CODE_W{1'b0}};
      for (int i = 0; i < DATA_W; i++) begin
         code_o[data_idx(i)] = data_i[i];
      end
      code_o[P1_IDX] = parity8(data_i & P1_MASK);
      code_o[P2_IDX] = parity8(data_i & P2_MASK);
      code_o[P4_IDX] = parity8(data_i & P4_MASK);
      code_o[P8_IDX] = parity8(data_i & P8_MASK);
   end

endmodule

// File: rtl/hamming_fsk_tx.sv
// Hamming(12,8) transmit path: single-entry byte buffer, encoder and start/stop framed
// serializer driving the FSK modulator bit input, one bit every CLKS_PER_BIT clocks.
module hamming_fsk_tx
   import hamming_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int CNT_W        = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              tx_bit,
   output logic              tx_active,
   output logic [CODE_W-1:0] code_out,
   output logic              frame_done
);

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]       LAST_DATA = 4'd11;

   tx_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [3:0]        idx_q, idx_d;
   logic [CODE_W-1:0] shift_q, shift_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic [DATA_W-1:0] buf_q, buf_d;
   logic              buf_valid_q, buf_valid_d;
   logic              in_ready_q, in_ready_d;
   logic              tx_bit_q, tx_bit_d;
   logic              tx_active_q, tx_active_d;
   logic              frame_done_q, frame_done_d;

   logic [CODE_W-1:0] enc_code_s;
   logic              accept_s;
   logic              bit_end_s;
   logic              load_s;

   hamming_encode_12_8 u_encode (
      .data_i (buf_q),
      .code_o (enc_code_s)
   );

   assign accept_s  = in_valid && in_ready_q;
   assign bit_end_s = (cnt_q == CNT_LAST);

   // Next-state, buffer and registered-output computation.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      code_d      = code_q;
      buf_d       = buf_q;
      buf_valid_d = buf_valid_q;
      load_s      = 1'b0;

      // Accept requires an empty buffer and load a full one, so the two never overlap.
      if (accept_s) begin
         buf_d       = in_data;
         buf_valid_d = 1'b1;
      end else begin
         buf_d = buf_q;
      end

      case (state_q)
         TX_IDLE: begin
            if (buf_valid_q) begin
               load_s = 1'b1;
            end else begin
               cnt_d = {CNT_W{1'b0}};
            end
         end
         TX_START: begin
            if (bit_end_s) begin
               state_d = TX_DATA;
               idx_d   = 4'd0;
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         TX_DATA: begin
            if (bit_end_s) begin
               shift_d = shift_q >> 1;
               cnt_d   = {CNT_W{1'b0}};
               if (idx_q == LAST_DATA) begin
                  state_d = TX_STOP;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         TX_STOP: begin
            if (bit_end_s) begin
               if (buf_valid_q) begin
                  load_s = 1'b1;
               end else begin
                  state_d = TX_IDLE;
                  cnt_d   = {CNT_W{1'b0}};
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = TX_IDLE;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase

      if (load_s) begin
         state_d     = TX_START;
         cnt_d       = {CNT_W{1'b0}};
         shift_d     = enc_code_s;
         code_d      = enc_code_s;
         buf_valid_d = 1'b0;
      end else begin
         code_d = code_q;
      end

      in_ready_d   = ~buf_valid_d;
      tx_active_d  = (state_d != TX_IDLE);
      frame_done_d = (state_d == TX_STOP) && (cnt_d == CNT_LAST);

      case (state_d)
         TX_IDLE:  tx_bit_d = 1'b1;
         TX_START: tx_bit_d = 1'b0;
         TX_DATA:  tx_bit_d = shift_d[0];
         TX_STOP:  tx_bit_d = 1'b1;
         default:  tx_bit_d = 1'b1;
      endcase
   end

   // State and output registers; reset drops any buffered byte and idles the line high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= TX_IDLE;
         cnt_q        <= {CNT_W{1'b0}};
         idx_q        <= 4'd0;
         shift_q      <= {CODE_W{1'b0}};
         code_q       <= {CODE_W{1'b0}};
         buf_q        <= {DATA_W{1'b0}};
         buf_valid_q  <= 1'b0;
         in_ready_q   <= 1'b1;
         tx_bit_q     <= 1'b1;
         tx_active_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shift_q      <= shift_d;
         code_q       <= code_d;
         buf_q        <= buf_d;
         buf_valid_q  <= buf_valid_d;
         in_ready_q   <= in_ready_d;
         tx_bit_q     <= tx_bit_d;
         tx_active_q  <= tx_active_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign tx_bit     = tx_bit_q;
   assign tx_active  = tx_active_q;
   assign code_out   = code_q;
   assign frame_done = frame_done_q;

endmodule
